ray_generator_raster: RTL and testbench

Parametrised successor to the single-request folded ray generator. It scans a whole frame on its own and emits one normalised primary-ray direction per sampled pixel, tagged with that pixel's coordinates, over a valid/ready stream with backpressure. The camera basis is computed once per frame rather than once per ray, and pixel stride is configurable for sub-sampled preview frames. It sits between the frame-level controller (which issues `start_in`) and the ray-march core (which consumes rays).

---
 rtl/ray_generator_raster_pkg.sv | 69 ++++++
 rtl/fp_inv_sqrt_folded.sv | 58 +++++
 rtl/raster_scan_counter.sv | 53 +++++
 rtl/ray_generator_raster.sv | 176 +++++++++++++++++
 tb/tb_ray_generator_raster.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_generator_raster_pkg.sv
// ray_generator_raster_pkg: Q16.16 vector arithmetic, display defaults and raster ray generator state enum
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 8
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 4
`endif
`ifndef H_BITS
`define H_BITS 4
`endif
`ifndef V_BITS
`define V_BITS 3
`endif

package ray_generator_raster_pkg;

    localparam int NUM_FRAC_DIGITS = 16;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    localparam fp FP_ONE  = 32'sh0001_0000;
    localparam fp FP_ZERO = 32'sh0000_0000;
    localparam vec3 Y_AXIS = '{FP_ZERO, FP_ONE, FP_ZERO};

    typedef enum logic [3:0] {
        RG_IDLE,
        RG_BASIS_R,
        RG_BASIS_U,
        RG_PIXEL,
        RG_SCALE,
        RG_NORM_REQ,
        RG_NORM_WAIT,
        RG_EMIT,
        RG_DONE
    } raygen_state_e;

    function automatic fp fp_mul(input fp a, input fp b);
        return fp'((64'(a) * 64'(b)) >>> NUM_FRAC_DIGITS);
    endfunction

    function automatic fp int_to_fp(input int i);
        return fp'(i <<< NUM_FRAC_DIGITS);
    endfunction

    function automatic vec3 vec_add(input vec3 a, input vec3 b);
        return '{a.x + b.x, a.y + b.y, a.z + b.z};
    endfunction

    function automatic vec3 vec_scaled(input vec3 a, input fp s);
        return '{fp_mul(a.x, s), fp_mul(a.y, s), fp_mul(a.z, s)};
    endfunction

    function automatic vec3 vec_cross(input vec3 a, input vec3 b);
        return '{fp_mul(a.y, b.z) - fp_mul(a.z, b.y),
                 fp_mul(a.z, b.x) - fp_mul(a.x, b.z),
                 fp_mul(a.x, b.y) - fp_mul(a.y, b.x)};
    endfunction

    function automatic fp vec_dot(input vec3 a, input vec3 b);
        return fp_mul(a.x, b.x) + fp_mul(a.y, b.y) + fp_mul(a.z, b.z);
    endfunction

endpackage

// File: rtl/fp_inv_sqrt_folded.sv
// fp_inv_sqrt_folded: bit-serial 1/sqrt(x) in Q16.16, one result bit per cycle, 32-cycle latency
module fp_inv_sqrt_folded
    import ray_generator_raster_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  fp    x_in,
    output logic ready_out,
    output logic valid_out,
    output fp    y_out
);

    // y is the largest value with y*y*x <= 2^(3F), found MSB first
    localparam logic [95:0] ISQ_LIMIT = 96'(1) << (3 * NUM_FRAC_DIGITS);

    logic [31:0] r_x;
    logic [30:0] r_y;
    logic [4:0]  r_bit;
    logic        r_busy;
    logic        r_valid;
    logic [30:0] w_c;
    logic [95:0] w_prod;

    assign w_c       = r_y | (31'd1 << r_bit);
    assign w_prod    = 96'(w_c) * 96'(w_c) * 96'(r_x);
    assign ready_out = !r_busy;
    assign valid_out = r_valid;
    assign y_out     = fp'({1'b0, r_y});

    // accept a request when idle, then resolve one result bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!r_busy && valid_in) begin
                r_x    <= x_in;
                r_y    <= '0;
                r_bit  <= 5'd30;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_prod <= ISQ_LIMIT) r_y <= w_c;
                if (r_bit == 5'd0) begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end else begin
                    r_bit <= r_bit - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: strided h/v pixel counter with one guard bit so end-of-line compares never wrap
module raster_scan_counter #(
    parameter int W      = 8,
    parameter int H      = 4,
    parameter int H_BITS = 4,
    parameter int V_BITS = 3,
    parameter int H_STEP = 1,
    parameter int V_STEP = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              clear_in,
    input  logic              advance_in,
    output logic [H_BITS:0]   h_out,
    output logic [V_BITS:0]   v_out,
    output logic              last_out
);

    localparam logic [H_BITS:0] L_W  = (H_BITS + 1)'(W);
    localparam logic [V_BITS:0] L_H  = (V_BITS + 1)'(H);
    localparam logic [H_BITS:0] L_HS = (H_BITS + 1)'(H_STEP);
    localparam logic [V_BITS:0] L_VS = (V_BITS + 1)'(V_STEP);

    logic [H_BITS:0] r_h;
    logic [V_BITS:0] r_v;
    logic [H_BITS:0] w_h_next;
    logic [V_BITS:0] w_v_next;
    logic            w_h_wrap;
    logic            w_v_wrap;

    assign w_h_next = r_h + L_HS;
    assign w_v_next = r_v + L_VS;
    assign w_h_wrap = w_h_next >= L_W;
    assign w_v_wrap = w_v_next >= L_H;
    assign last_out = w_h_wrap && w_v_wrap;
    assign h_out    = r_h;
    assign v_out    = r_v;

    // step along the row, moving to the next sampled row at end of line
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_h <= '0;
            r_v <= '0;
        end else if (clear_in) begin
            r_h <= '0;
            r_v <= '0;
        end else if (advance_in) begin
            r_h <= w_h_wrap ? '0 : w_h_next;
            if (w_h_wrap) r_v <= w_v_wrap ? '0 : w_v_next;
        end
    end

endmodule

// File: rtl/ray_generator_raster.sv
// ray_generator_raster: scans a frame and streams one normalised primary ray per sampled pixel.
// Optional RAYGEN_FOV_SCALE_EN adds fov_scale_in, latched at start and applied to px/py.
module ray_generator_raster
    import ray_generator_raster_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS,
    parameter int H_STEP         = 1,
    parameter int V_STEP         = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  vec3               cam_forward_in,
`ifdef RAYGEN_FOV_SCALE_EN
    input  fp                 fov_scale_in,
`endif
    input  logic              ready_in,
    output logic              valid_out,
    output logic [H_BITS-1:0] hcount_out,
    output logic [V_BITS-1:0] vcount_out,
    output vec3               ray_direction_out,
    output logic              busy_out,
    output logic              frame_done_out
);

    localparam fp INV_H = fp'(FP_ONE / DISPLAY_HEIGHT);

    raygen_state_e r_state;
    vec3           r_fwd;
    vec3           r_right;
    vec3           r_up;
    vec3           r_sr;
    vec3           r_su;
    vec3           r_rd;
    fp             r_px;
    fp             r_py;
    fp             r_isq_x;
    logic          r_isq_valid;
`ifdef RAYGEN_FOV_SCALE_EN
    fp             r_scale;
`endif

    logic [H_BITS:0] w_h;
    logic [V_BITS:0] w_v;
    logic            w_last;
    logic            w_isq_ready;
    logic            w_isq_valid;
    fp               w_isq_y;
    fp               w_px_base;
    fp               w_py_base;
    fp               w_px;
    fp               w_py;
    vec3             w_rd;

    assign w_px_base = fp_mul(int_to_fp(2 * int'(w_h) - DISPLAY_WIDTH), INV_H);
    assign w_py_base = fp_mul(int_to_fp(DISPLAY_HEIGHT - 2 * int'(w_v)), INV_H);
`ifdef RAYGEN_FOV_SCALE_EN
    assign w_px = fp_mul(w_px_base, r_scale);
    assign w_py = fp_mul(w_py_base, r_scale);
`else
    assign w_px = w_px_base;
    assign w_py = w_py_base;
`endif
    assign w_rd = vec_add(vec_add(r_sr, r_su), r_fwd);

    raster_scan_counter #(
        .W      (DISPLAY_WIDTH),
        .H      (DISPLAY_HEIGHT),
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .H_STEP (H_STEP),
        .V_STEP (V_STEP)
    ) u_scan (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .clear_in   (r_state == RG_IDLE && start_in),
        .advance_in (r_state == RG_EMIT && ready_in),
        .h_out      (w_h),
        .v_out      (w_v),
        .last_out   (w_last)
    );

    fp_inv_sqrt_folded u_isq (
        .clk       (clk_in),
        .rst       (!rst_n_in),
        .valid_in  (r_isq_valid),
        .x_in      (r_isq_x),
        .ready_out (w_isq_ready),
        .valid_out (w_isq_valid),
        .y_out     (w_isq_y)
    );

    // frame sequencer: basis once per frame, then one folded ray at a time
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state           <= RG_IDLE;
            r_fwd             <= '0;
            r_right           <= '0;
            r_up              <= '0;
            r_sr              <= '0;
            r_su              <= '0;
            r_rd              <= '0;
            r_px              <= '0;
            r_py              <= '0;
            r_isq_x           <= '0;
            r_isq_valid       <= 1'b0;
`ifdef RAYGEN_FOV_SCALE_EN
            r_scale           <= FP_ONE;
`endif
            valid_out         <= 1'b0;
            hcount_out        <= '0;
            vcount_out        <= '0;
            ray_direction_out <= '0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
        end else begin
            r_isq_valid    <= 1'b0;
            frame_done_out <= 1'b0;
            case (r_state)
                RG_IDLE: if (start_in) begin
                    r_fwd    <= cam_forward_in;
`ifdef RAYGEN_FOV_SCALE_EN
                    r_scale  <= fov_scale_in;
`endif
                    busy_out <= 1'b1;
                    r_state  <= RG_BASIS_R;
                end
                RG_BASIS_R: begin
                    r_right <= vec_cross(Y_AXIS, r_fwd);
                    r_state <= RG_BASIS_U;
                end
                RG_BASIS_U: begin
                    r_up    <= vec_cross(r_fwd, r_right);
                    r_state <= RG_PIXEL;
                end
                RG_PIXEL: begin
                    r_px    <= w_px;
                    r_py    <= w_py;
                    r_state <= RG_SCALE;
                end
                RG_SCALE: begin
                    r_sr <= vec_scaled(r_right, r_px);
                    r_su <= vec_scaled(r_up, r_py);
                    if (w_isq_ready) r_state <= RG_NORM_REQ;
                end
                RG_NORM_REQ: begin
                    r_rd        <= w_rd;
                    r_isq_x     <= vec_dot(w_rd, w_rd);
                    r_isq_valid <= 1'b1;
                    r_state     <= RG_NORM_WAIT;
                end
                RG_NORM_WAIT: if (w_isq_valid) begin
                    ray_direction_out <= vec_scaled(r_rd, w_isq_y);
                    hcount_out        <= w_h[H_BITS-1:0];
                    vcount_out        <= w_v[V_BITS-1:0];
                    valid_out         <= 1'b1;
                    r_state           <= RG_EMIT;
                end
                RG_EMIT: if (ready_in) begin
                    valid_out      <= 1'b0;
                    frame_done_out <= w_last;
                    r_state        <= w_last ? RG_DONE : RG_PIXEL;
                end
                RG_DONE: begin
                    busy_out <= 1'b0;
                    r_state  <= RG_IDLE;
                end
                default: r_state <= RG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_generator_raster.sv
// tb_ray_generator_raster: directed checks of raster order, directions, stalls, restart and reset
module tb_ray_generator_raster;
    import ray_generator_raster_pkg::*;

    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start2, ready;
    logic       valid, busy, done, valid2, busy2, done2;
    logic [3:0] hc, hc2;
    logic [2:0] vc, vc2;
    vec3        fwd, dir, dir2, snap_dir;
`ifdef RAYGEN_FOV_SCALE_EN
    fp          fov;
`endif

    int n_chk = 0, n_pass = 0;
    int n_rays = 0, n_rays2 = 0, n_done = 0, n_done2 = 0;
    int base, dbase, t;
    logic [6:0] rec_hv [256];
    fp          rec_x [256], rec_y [256], rec_z [256];
    logic [6:0] rec2_hv [16];
    logic [6:0] snap_hv;

    ray_generator_raster #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(4), .V_BITS(3), .H_STEP(1), .V_STEP(1)
    ) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .cam_forward_in(fwd),
`ifdef RAYGEN_FOV_SCALE_EN
        .fov_scale_in(fov),
`endif
        .ready_in(ready), .valid_out(valid), .hcount_out(hc), .vcount_out(vc),
        .ray_direction_out(dir), .busy_out(busy), .frame_done_out(done)
    );

    ray_generator_raster #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(4), .V_BITS(3), .H_STEP(2), .V_STEP(2)
    ) u_dut_s2 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start2), .cam_forward_in(fwd),
`ifdef RAYGEN_FOV_SCALE_EN
        .fov_scale_in(FP_ONE),
`endif
        .ready_in(1'b1), .valid_out(valid2), .hcount_out(hc2), .vcount_out(vc2),
        .ray_direction_out(dir2), .busy_out(busy2), .frame_done_out(done2)
    );

    // record every handshake and done pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && valid && ready && n_rays < 256) begin
            rec_hv[n_rays] = {hc, vc};
            rec_x[n_rays]  = dir.x;
            rec_y[n_rays]  = dir.y;
            rec_z[n_rays]  = dir.z;
            n_rays++;
        end
        if (done) n_done++;
        if (rst_n && valid2 && n_rays2 < 16) begin
            rec2_hv[n_rays2] = {hc2, vc2};
            n_rays2++;
        end
        if (done2) n_done2++;
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    endtask

    function automatic longint rf(input real r);
        return longint'($rtoi(r * 65536.0));
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rays(input int n, input string tag);
        int k = 0;
        while (n_rays < n && k < 4000) begin
            @(posedge clk);
            k++;
        end
        chk(tag, n_rays, n, 0);
    endtask

    task automatic wait_done(input int db, input string tag);
        int k = 0;
        while (n_done <= db && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_done - db, 1, 0);
    endtask

    task automatic check_frame(input int b, input string tag);
        int k = 0;
        for (int v = 0; v < H; v++)
            for (int h = 0; h < W; h++) begin
                chk($sformatf("%s_ray%0d", tag, k), rec_hv[b + k], h * 8 + v, 0);
                k++;
            end
    endtask

    task automatic check_dir(input int idx, input real ex, input real ey, input real ez, input string tag);
        chk({tag, "_x"}, rec_x[idx], rf(ex), 4);
        chk({tag, "_y"}, rec_y[idx], rf(ey), 4);
        chk({tag, "_z"}, rec_z[idx], rf(ez), 4);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        ready  = 1'b1;
        fwd    = '{FP_ZERO, FP_ZERO, FP_ONE};
`ifdef RAYGEN_FOV_SCALE_EN
        fov    = FP_ONE;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_done", done, 0, 0);
        chk("rst_hcount", hc, 0, 0);
        chk("rst_vcount", vc, 0, 0);
        chk("rst_dir_z", dir.z, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // frame A: restart attempt, camera change and a 5-cycle stall mid-frame
        base  = n_rays;
        dbase = n_done;
        pulse_start();
        chk("busy_after_start", busy, 1, 0);
        wait_rays(base + 5, "wait_ray5");
        #1;
        fwd = '{FP_ONE, FP_ZERO, FP_ZERO};
        pulse_start();
        wait_rays(base + 10, "wait_ray10");
        #1;
        ready = 1'b0;
        t = 0;
        while (!valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid_seen", valid, 1, 0);
        snap_hv  = {hc, vc};
        snap_dir = dir;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_c%0d", i), valid, 1, 0);
            chk($sformatf("stall_data_c%0d", i), ({hc, vc} == snap_hv && dir == snap_dir) ? 1 : 0, 1, 0);
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_done(dbase, "frameA_done");
        repeat (3) @(negedge clk);
        chk("frameA_rays", n_rays - base, 32, 0);
        chk("frameA_done_pulses", n_done - dbase, 1, 0);
        chk("frameA_busy_clear", busy, 0, 0);
        check_frame(base, "frameA");
        check_dir(base + 0, -0.816497, 0.408248, 0.408248, "dir_0_0");
        check_dir(base + 20, 0.0, 0.0, 1.0, "dir_4_2");
        check_dir(base + 31, 0.801784, -0.267261, 0.534522, "dir_7_3");
        @(posedge clk); #1;
        fwd = '{FP_ZERO, FP_ZERO, FP_ONE};

        // reset while ray 3 is normalising
        base  = n_rays;
        dbase = n_done;
        pulse_start();
        wait_rays(base + 3, "wait_ray3");
        repeat (10) @(posedge clk);
        #1;
        chk("midray_busy", busy, 1, 0);
        chk("midray_hcount", hc, 2, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", valid, 0, 0);
        chk("async_rst_busy", busy, 0, 0);
        chk("async_rst_hcount", hc, 0, 0);
        chk("async_rst_vcount", vc, 0, 0);
        chk("async_rst_dir_x", dir.x, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abandon_no_done", n_done - dbase, 0, 0);
        chk("abandon_rays", n_rays - base, 3, 0);

        // full frame after reset
        base  = n_rays;
        dbase = n_done;
        pulse_start();
        wait_done(dbase, "frameB_done");
        repeat (3) @(negedge clk);
        chk("frameB_rays", n_rays - base, 32, 0);
        check_frame(base, "frameB");

        // strided preview frame
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        t = 0;
        while (n_done2 == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("s2_done_pulses", n_done2, 1, 0);
        chk("s2_rays", n_rays2, 8, 0);
        chk("s2_busy_clear", busy2, 0, 0);
        for (int k = 0; k < 8; k++)
            chk($sformatf("s2_ray%0d", k), rec2_hv[k], (2 * (k % 4)) * 8 + 2 * (k / 4), 0);
        chk("s2_last_dir_x", dir2.x, rf(0.707107), 4);
        chk("s2_last_dir_z", dir2.z, rf(0.707107), 4);

`ifdef RAYGEN_FOV_SCALE_EN
        // half field of view
        @(posedge clk); #1;
        fov   = 32'sh0000_8000;
        base  = n_rays;
        dbase = n_done;
        pulse_start();
        wait_rays(base + 1, "fov_first_ray");
        chk("fov_dir_x", rec_x[base], rf(-0.666667), 2);
        chk("fov_dir_y", rec_y[base], rf(0.333333), 2);
        chk("fov_dir_z", rec_z[base], rf(0.666667), 2);
        wait_done(dbase, "fov_done");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
